// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the phi0-phase clock control blocks.
package cpu_clk_pkg;

  localparam int unsigned SYNC_STAGES_DEF  = 2;
  localparam int unsigned GUARD_CLKS_DEF   = 4;
  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned MAX_HALT_PHI_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ARM         = 3'd1,
    ST_STOPPING    = 3'd2,
    ST_GUARD       = 3'd3,
    ST_HALTED      = 3'd4,
    ST_RELEASE_ARM = 3'd5,
    ST_RESUMING    = 3'd6
  } halt_state_e;

  // Bits needed to hold the value n (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/phi_edge_sync.sv
// Synchronises the free-running phi0 into clk and emits registered
// one-clk rise/fall strobes, lagging the true edge by STAGES+1 clks.
module phi_edge_sync
  import cpu_clk_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic phi_in,
  output logic phi_rise,
  output logic phi_fall
);

  logic [STAGES-1:0] sync_q;
  logic              sync_d;

  // Synchroniser chain plus delay flop and registered edge strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      sync_d   <= 1'b0;
      phi_rise <= 1'b0;
      phi_fall <= 1'b0;
    end else begin
      sync_q   <= {sync_q[STAGES-2:0], phi_in};
      sync_d   <= sync_q[STAGES-1];
      phi_rise <= sync_q[STAGES-1] & ~sync_d;
      phi_fall <= ~sync_q[STAGES-1] & sync_d;
    end
  end

endmodule

// File: rtl/cpu_halt_ctrl.sv
// Requester side of the 6502 phi0 HALT interface: stops the CPU clock
// on behalf of a DMA master and hands back a grant/release handshake.
// Optional watchdog on the halt length: define CPU_HALT_WATCHDOG_EN.
module cpu_halt_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int unsigned GUARD_CLKS   = GUARD_CLKS_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
`ifdef CPU_HALT_WATCHDOG_EN
  ,
  parameter int unsigned MAX_HALT_PHI = MAX_HALT_PHI_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phi0_in,
  input  logic             dma_req,
  input  logic             dma_done,
  output logic             HALT,
  output logic             dma_grant,
  output logic             busy,
  output logic             phi_rise,
  output logic             phi_fall,
  output logic [CNT_W-1:0] halted_cycles,
  output logic             timeout_err
);

  localparam int unsigned GUARD_W = cnt_width(GUARD_CLKS);

  halt_state_e          state;
  logic [GUARD_W-1:0]   guard_cnt;
  logic                 abort_q;

  phi_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_phi_sync (
    .clk      (clk),
    .rst      (rst),
    .phi_in   (phi0_in),
    .phi_rise (phi_rise),
    .phi_fall (phi_fall)
  );

`ifdef CPU_HALT_WATCHDOG_EN
  localparam int unsigned WD_W  = cnt_width(MAX_HALT_PHI);
  localparam int unsigned WD_XW = WD_W + 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire_c;

  // Limit reached once the falls seen so far plus this one hit the maximum.
  assign wd_expire_c = (WD_XW'(wd_cnt) + WD_XW'(phi_fall)) >= WD_XW'(MAX_HALT_PHI);
`else
  assign timeout_err = 1'b0;
`endif

  // Halt sequencer: arm on rise, latch on fall, guard, grant, release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      HALT          <= 1'b0;
      dma_grant     <= 1'b0;
      busy          <= 1'b0;
      halted_cycles <= '0;
      guard_cnt     <= '0;
      abort_q       <= 1'b0;
`ifdef CPU_HALT_WATCHDOG_EN
      wd_cnt        <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (dma_req) begin
            state   <= ST_ARM;
            busy    <= 1'b1;
            abort_q <= 1'b0;
          end
        end

        // A dropped request wins over a simultaneous rise: HALT never asserts.
        ST_ARM: begin
          if (!dma_req) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (phi_rise) begin
            HALT  <= 1'b1;
            state <= ST_STOPPING;
          end
        end

        ST_STOPPING: begin
          if (!dma_req) abort_q <= 1'b1;
          if (phi_fall) begin
            halted_cycles <= '0;
            guard_cnt     <= GUARD_W'(GUARD_CLKS);
            state         <= ST_GUARD;
`ifdef CPU_HALT_WATCHDOG_EN
            wd_cnt        <= '0;
`endif
          end
        end

        // Let the stopped clock settle; skip the grant if the master left.
        ST_GUARD: begin
          if (guard_cnt <= GUARD_W'(1)) begin
            if (abort_q || !dma_req) begin
              state <= ST_RELEASE_ARM;
            end else begin
              dma_grant <= 1'b1;
              state     <= ST_HALTED;
            end
          end else begin
            guard_cnt <= guard_cnt - GUARD_W'(1);
            if (!dma_req) abort_q <= 1'b1;
          end
`ifdef CPU_HALT_WATCHDOG_EN
          if (phi_fall && (wd_cnt != {WD_W{1'b1}})) wd_cnt <= wd_cnt + WD_W'(1);
`endif
        end

        ST_HALTED: begin
          if (phi_fall && (halted_cycles != {CNT_W{1'b1}})) begin
            halted_cycles <= halted_cycles + CNT_W'(1);
          end
`ifdef CPU_HALT_WATCHDOG_EN
          if (wd_expire_c) begin
            dma_grant   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_RELEASE_ARM;
          end else begin
            if (phi_fall) wd_cnt <= wd_cnt + WD_W'(1);
            if (dma_done) begin
              dma_grant <= 1'b0;
              state     <= ST_RELEASE_ARM;
            end
          end
`else
          if (dma_done) begin
            dma_grant <= 1'b0;
            state     <= ST_RELEASE_ARM;
          end
`endif
        end

        // Drop HALT half a phi period ahead of the generator's latch point.
        ST_RELEASE_ARM: begin
          if (phi_rise) begin
            HALT  <= 1'b0;
            state <= ST_RESUMING;
          end
        end

        ST_RESUMING: begin
          if (phi_fall) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          HALT  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
